fifo_rd_streamer: RTL

- Sits directly downstream of the synchronous FIFO and drains it through the FIFO read port (rden / empty / rddata).
- Converts the FIFO's 1-cycle-latency read into a valid/ready stream with full throughput and no combinational path from fifo_empty to m_valid.
- Provides a flush mode that discards all buffered and FIFO-resident data and reports completion.

---
 rtl/fifo_pkg.sv | 24 ++
 rtl/fifo_skid_buf.sv | 72 +++++++
 rtl/fifo_rd_streamer.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared definitions for the FIFO read-side streamer.
//   DATA_W_DEF / BUF_DEPTH_DEF : default data width and skid buffer depth
//   rd_state_e                 : streamer control states
//   fifo_data_t                : one FIFO word at the default width
//   sat_inc32()                : saturating 32-bit increment for statistics
package fifo_pkg;

  localparam int DATA_W_DEF    = 128;
  localparam int BUF_DEPTH_DEF = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } rd_state_e;

  typedef logic [DATA_W_DEF-1:0] fifo_data_t;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
  endfunction

endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: DEPTH-entry register buffer behind the FIFO read port.
//   clk, rstn        : clock, asynchronous active-low reset
//   clear            : drop all held entries (pointers and count to zero)
//   push, push_data  : write one entry at the tail
//   pop              : retire the head entry
//   head_data        : head entry, read straight out of register storage
//   occ              : number of entries held (0..DEPTH)
// A simultaneous push and pop advances both pointers and keeps occ unchanged.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = BUF_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     clear,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic [$clog2(DEPTH):0]   occ
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [OCC_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  // A full buffer still accepts a push when the head leaves on the same edge.
  assign do_pop  = pop && (count != {OCC_W{1'b0}});
  assign do_push = push && ((count != OCC_W'(DEPTH)) || do_pop);

  // Pointer and occupancy bookkeeping; pointers wrap because DEPTH is a power of 2.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {OCC_W{1'b0}};
    end else if (clear) begin
      wr_ptr <= {PTR_W{1'b0}};
      rd_ptr <= {PTR_W{1'b0}};
      count  <= {OCC_W{1'b0}};
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + OCC_W'(1);
        2'b01:   count <= count - OCC_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; cleared on reset so nothing stale can reach m_data afterwards.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= {DATA_W{1'b0}};
    end else if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  assign head_data = mem[rd_ptr];
  assign occ       = count;

endmodule

// File: rtl/fifo_rd_streamer.sv
// fifo_rd_streamer: drains a synchronous FIFO (1-cycle read latency) into a
// valid/ready stream at full throughput, with a flush mode.
//   clk, rstn                 : clock, asynchronous active-low reset
//   fifo_rden/empty/rddata    : FIFO read port
//   i_en                      : enable draining
//   i_flush                   : single-cycle flush request (beats i_en)
//   m_valid/m_data/m_ready    : output stream; m_valid depends on registers only
//   o_busy                    : not idle, or data held / read in flight
//   o_flush_done              : one-cycle pulse when a flush completes
//   o_occ                     : skid buffer entries held
// Optional macro FIFO_RD_STATS_EN adds o_beat_cnt / o_stall_cnt (saturating,
// cleared by reset and by i_flush).
module fifo_rd_streamer
  import fifo_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF,
  parameter int RD_LAT    = 1
) (
  input  logic                        clk,
  input  logic                        rstn,
  output logic                        fifo_rden,
  input  logic                        fifo_empty,
  input  logic [DATA_W-1:0]           fifo_rddata,
  input  logic                        i_en,
  input  logic                        i_flush,
  output logic                        m_valid,
  output logic [DATA_W-1:0]           m_data,
  input  logic                        m_ready,
  output logic                        o_busy,
  output logic                        o_flush_done,
  output logic [$clog2(BUF_DEPTH):0]  o_occ
`ifdef FIFO_RD_STATS_EN
  ,
  output logic [31:0]                 o_beat_cnt,
  output logic [31:0]                 o_stall_cnt
`endif
);

  localparam int OCC_W = $clog2(BUF_DEPTH) + 1;
  localparam int INF_W = $clog2(RD_LAT + 1);
  localparam logic [OCC_W:0] DEPTH_V = (OCC_W+1)'(BUF_DEPTH);

  rd_state_e          state;
  rd_state_e          next_state;
  logic [INF_W-1:0]   inflight;
  logic [OCC_W-1:0]   occ;
  logic [OCC_W:0]     demand;
  logic               pop;
  logic               push;
  logic               clear;
  logic               has_room;
  logic               drained;
  logic               flush_done;

  assign m_valid  = (occ != {OCC_W{1'b0}}) && (state != FLUSH);
  assign pop      = m_valid && m_ready;
  // Entries that will be owed space after this edge; pop implies occ>=1 so no underflow.
  assign demand   = (OCC_W+1)'(occ) + (OCC_W+1)'(inflight) - (OCC_W+1)'(pop);
  assign has_room = demand < DEPTH_V;
  assign drained  = fifo_empty && (inflight == {INF_W{1'b0}});
  // Returning data is discarded while flushing.
  assign push     = (inflight != {INF_W{1'b0}}) && (state != FLUSH);
  assign clear    = i_flush && (state != FLUSH);

  fifo_skid_buf #(
    .DATA_W (DATA_W),
    .DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (clk),
    .rstn      (rstn),
    .clear     (clear),
    .push      (push),
    .push_data (fifo_rddata),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

  // Next-state and read-issue decode. IDLE with i_en already issues the first
  // read so the first beat appears two cycles after enable.
  always_comb begin
    next_state = state;
    fifo_rden  = 1'b0;
    case (state)
      IDLE: begin
        if (i_flush) begin
          next_state = FLUSH;
        end else if (i_en) begin
          next_state = RUN;
          fifo_rden  = !fifo_empty && has_room;
        end else begin
          next_state = IDLE;
        end
      end
      RUN: begin
        if (i_flush) begin
          next_state = FLUSH;
        end else if (i_en) begin
          next_state = RUN;
          fifo_rden  = !fifo_empty && has_room;
        end else if (inflight == {INF_W{1'b0}}) begin
          next_state = IDLE;
        end else begin
          next_state = RUN;
        end
      end
      FLUSH: begin
        fifo_rden = !fifo_empty;
        if (drained) begin
          next_state = IDLE;
        end else begin
          next_state = FLUSH;
        end
      end
      default: begin
        next_state = IDLE;
        fifo_rden  = 1'b0;
      end
    endcase
  end

  // State register, in-flight read tracker and flush completion pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= IDLE;
      inflight   <= {INF_W{1'b0}};
      flush_done <= 1'b0;
    end else begin
      state      <= next_state;
      inflight   <= fifo_rden ? INF_W'(1) : {INF_W{1'b0}};
      flush_done <= (state == FLUSH) && drained;
    end
  end

  assign o_occ        = occ;
  assign o_flush_done = flush_done;
  assign o_busy       = (state != IDLE) || (occ != {OCC_W{1'b0}}) ||
                        (inflight != {INF_W{1'b0}});

`ifdef FIFO_RD_STATS_EN
  logic [31:0] beat_cnt;
  logic [31:0] stall_cnt;

  // Beat and stall statistics, saturating at all-ones.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      beat_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else if (i_flush) begin
      beat_cnt  <= 32'd0;
      stall_cnt <= 32'd0;
    end else begin
      if (pop)                 beat_cnt  <= sat_inc32(beat_cnt);
      if (m_valid && !m_ready) stall_cnt <= sat_inc32(stall_cnt);
    end
  end

  assign o_beat_cnt  = beat_cnt;
  assign o_stall_cnt = stall_cnt;
`endif

endmodule
